hit_encoder: RTL and testbench

Front end for the whack-a-mole player input: the producer side of the 3-bit hit-code interface that the match logic consumes.
- Takes five raw active-low mole pushbuttons and synchronizes and debounces each one.
- Detects new presses and emits one encoded hit code (001..101) per press, held for a fixed window, then returns to 000.
- Sits between the board buttons and the game datapath's user-input port.

---
 rtl/hit_encoder_pkg.sv | 41 ++++
 rtl/button_debouncer.sv | 46 ++++
 rtl/hit_encoder.sv | 132 +++++++++++++
 tb/tb_hit_encoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/hit_encoder_pkg.sv
// Shared constants, hit-code values and FSM states for the whack-a-mole hit encoder.
package hit_encoder_pkg;

    localparam int NUM_MOLES = 5;
    localparam int HIT_W     = 3;

    localparam logic [HIT_W-1:0] HIT_NONE = 3'b000;
    localparam logic [HIT_W-1:0] HIT_M1   = 3'b001;
    localparam logic [HIT_W-1:0] HIT_M2   = 3'b010;
    localparam logic [HIT_W-1:0] HIT_M3   = 3'b011;
    localparam logic [HIT_W-1:0] HIT_M4   = 3'b100;
    localparam logic [HIT_W-1:0] HIT_M5   = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HOLD    = 2'b01,
        RELEASE = 2'b10
    } hit_state_t;

    // Lowest-index press wins; never yields 110 or 111.
    function automatic logic [HIT_W-1:0] encode_lowest(input logic [NUM_MOLES-1:0] presses);
        if (presses[0]) begin
            return HIT_M1;
        end else if (presses[1]) begin
            return HIT_M2;
        end else if (presses[2]) begin
            return HIT_M3;
        end else if (presses[3]) begin
            return HIT_M4;
        end else if (presses[4]) begin
            return HIT_M5;
        end else begin
            return HIT_NONE;
        end
    endfunction

    function automatic logic multi_hot(input logic [NUM_MOLES-1:0] presses);
        return |(presses & (presses - NUM_MOLES'(1)));
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stability counter for one active-high button level.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    // Synchronize the asynchronous button into the clock domain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // Flip the debounced level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_level <= 1'b0;
            r_cnt   <= {CW{1'b0}};
        end else if (r_sync2 == r_level) begin
            r_cnt   <= {CW{1'b0}};
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_level <= ~r_level;
            r_cnt   <= {CW{1'b0}};
        end else begin
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    assign level = r_level;

endmodule

// File: rtl/hit_encoder.sv
// Debounces five mole buttons and emits one held 3-bit hit code per fresh press.
// Optional build macro HIT_MULTI_REJECT_EN rejects simultaneous multi-button presses.
module hit_encoder
    import hit_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_MOLES-1:0] btn_n,
    output logic [HIT_W-1:0]     hit_code,
    output logic                 hit_valid,
    output logic                 busy,
    output logic                 multi_press
);

    localparam int HC_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

    logic [NUM_MOLES-1:0] w_level;
    logic [NUM_MOLES-1:0] r_level_prev;
    logic [NUM_MOLES-1:0] w_new_press;
    logic                 w_reject;

    hit_state_t           r_state;
    hit_state_t           w_next_state;
    logic [HC_W-1:0]      r_hold_cnt;
    logic [HC_W-1:0]      w_hold_cnt_next;
    logic [HIT_W-1:0]     r_hit_code;
    logic [HIT_W-1:0]     w_hit_code_next;
    logic                 r_hit_valid;
    logic                 w_hit_valid_next;
    logic                 r_multi;
    logic                 w_multi_next;
    logic                 r_busy;

    for (genvar g = 0; g < NUM_MOLES; g++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock(clock),
            .reset(reset),
            .raw  (~btn_n[g]),
            .level(w_level[g])
        );
    end

    assign w_new_press = w_level & ~r_level_prev;

`ifdef HIT_MULTI_REJECT_EN
    assign w_reject = multi_hot(w_new_press);
`else
    assign w_reject = 1'b0;
`endif

    // Next-state and next-output logic for the IDLE/HOLD/RELEASE sequencer.
    always_comb begin
        w_next_state     = r_state;
        w_hold_cnt_next  = r_hold_cnt;
        w_hit_code_next  = r_hit_code;
        w_hit_valid_next = 1'b0;
        w_multi_next     = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && (w_new_press != {NUM_MOLES{1'b0}})) begin
                    if (w_reject) begin
                        w_multi_next    = 1'b1;
                        w_hit_code_next = HIT_NONE;
                        w_next_state    = RELEASE;
                    end else begin
                        w_hit_code_next  = encode_lowest(w_new_press);
                        w_hold_cnt_next  = HC_W'(HOLD_CYCLES - 1);
                        w_hit_valid_next = 1'b1;
                        w_next_state     = HOLD;
                    end
                end else begin
                    w_hit_code_next = HIT_NONE;
                end
            end
            HOLD: begin
                // Losing enable ends the hold early, just like the counter expiring.
                if (!enable || (r_hold_cnt == {HC_W{1'b0}})) begin
                    w_hit_code_next = HIT_NONE;
                    w_next_state    = RELEASE;
                end else begin
                    w_hold_cnt_next = r_hold_cnt - HC_W'(1);
                end
            end
            RELEASE: begin
                w_hit_code_next = HIT_NONE;
                if (w_level == {NUM_MOLES{1'b0}}) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = RELEASE;
                end
            end
            default: begin
                w_hit_code_next = HIT_NONE;
                w_hold_cnt_next = {HC_W{1'b0}};
                w_next_state    = IDLE;
            end
        endcase
    end

    // State, edge-detect history and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_hold_cnt   <= {HC_W{1'b0}};
            r_hit_code   <= HIT_NONE;
            r_hit_valid  <= 1'b0;
            r_multi      <= 1'b0;
            r_busy       <= 1'b0;
            r_level_prev <= {NUM_MOLES{1'b0}};
        end else begin
            r_state      <= w_next_state;
            r_hold_cnt   <= w_hold_cnt_next;
            r_hit_code   <= w_hit_code_next;
            r_hit_valid  <= w_hit_valid_next;
            r_multi      <= w_multi_next;
            r_busy       <= (w_next_state != IDLE);
            r_level_prev <= w_level;
        end
    end

    assign hit_code    = r_hit_code;
    assign hit_valid   = r_hit_valid;
    assign busy        = r_busy;
    assign multi_press = r_multi;

endmodule

// File: tb/tb_hit_encoder.sv
// Directed scenarios plus random button traffic checked against a behavioural model.
module tb_hit_encoder;

    localparam int D = 4;
    localparam int H = 3;
`ifdef HIT_MULTI_REJECT_EN
    localparam bit MULTI_EN = 1'b1;
`else
    localparam bit MULTI_EN = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       enable;
    logic [4:0] btn_n;
    logic [2:0] hit_code;
    logic       hit_valid;
    logic       busy;
    logic       multi_press;

    hit_encoder #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .btn_n      (btn_n),
        .hit_code   (hit_code),
        .hit_valid  (hit_valid),
        .busy       (busy),
        .multi_press(multi_press)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int vcount;
    int ccount;
    int mcount;

    // Model: raw press history (index 0 = latest sampled edge), levels, and hit bookkeeping.
    logic [4:0] rh [0:D];
    logic [4:0] m_lvl;
    logic [4:0] m_prev;
    int         m_mode;
    int         m_left;
    logic [2:0] m_code;
    logic       m_valid;
    logic       m_busy;
    logic       m_multi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m <= D; m++) rh[m] = 5'b00000;
        m_lvl = 5'b00000; m_prev = 5'b00000; m_mode = 0; m_left = 0;
        m_code = 3'b000; m_valid = 1'b0; m_busy = 1'b0; m_multi = 1'b0;
    endtask

    task automatic model_step(input logic [4:0] rawp, input logic en);
        logic [4:0] lvl_old, new_lvl, newp;
        bit flip;
        lvl_old = m_lvl;
        new_lvl = m_lvl;
        // A level flips once the synchronized input has disagreed with it for D edges.
        for (int i = 0; i < 5; i++) begin
            flip = 1'b1;
            for (int j = 0; j < D; j++) if (rh[1 + j][i] == m_lvl[i]) flip = 1'b0;
            if (flip) new_lvl[i] = ~m_lvl[i];
        end
        for (int m = D; m >= 1; m--) rh[m] = rh[m - 1];
        rh[0] = rawp;
        newp = lvl_old & ~m_prev;
        m_valid = 1'b0;
        m_multi = 1'b0;
        if (m_mode == 0) begin
            if (en && newp != 5'b00000) begin
                if (MULTI_EN && $countones(newp) > 1) begin
                    m_multi = 1'b1; m_code = 3'b000; m_mode = 2;
                end else begin
                    for (int i = 4; i >= 0; i--) if (newp[i]) m_code = 3'(i + 1);
                    m_left = H; m_valid = 1'b1; m_mode = 1;
                end
            end
        end else if (m_mode == 1) begin
            m_left--;
            if (!en || m_left == 0) begin
                m_code = 3'b000; m_mode = 2;
            end
        end else begin
            if (lvl_old == 5'b00000) m_mode = 0;
        end
        m_busy = (m_mode != 0);
        m_prev = lvl_old;
        m_lvl  = new_lvl;
    endtask

    task automatic tick();
        logic [4:0] rawp;
        logic en;
        rawp = ~btn_n;
        en   = enable;
        @(posedge clock);
        #1;
        model_step(rawp, en);
        chk("hit_code", 32'(hit_code), 32'(m_code));
        chk("hit_valid", 32'(hit_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("multi_press", 32'(multi_press), 32'(m_multi));
        vcount += int'(hit_valid);
        ccount += int'(hit_code != 3'b000);
        mcount += int'(multi_press);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clr_counts();
        vcount = 0; ccount = 0; mcount = 0;
    endtask

    initial begin
        bit got;
        int r;
        clock = 1'b0; reset = 1'b0; enable = 1'b0; btn_n = 5'b11111;
        model_reset();
        clr_counts();
        #3;
        chk("rst_code", 32'(hit_code), 32'h0);
        chk("rst_valid", 32'(hit_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_multi", 32'(multi_press), 32'h0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;

        // 1: clean press of mole 3
        enable = 1'b1; clr_counts();
        btn_n = 5'b11011; ticks(20);
        btn_n = 5'b11111; ticks(10);
        chk("s1_valid_pulses", 32'(vcount), 32'd1);
        chk("s1_code_cycles", 32'(ccount), 32'd3);
        chk("s1_busy_idle", 32'(busy), 32'h0);

        // 2: bouncing mole 1
        clr_counts();
        for (int k = 0; k < 3; k++) begin
            btn_n = 5'b11110; ticks(2);
            btn_n = 5'b11111; ticks(2);
        end
        ticks(10);
        chk("s2_no_valid", 32'(vcount), 32'd0);
        chk("s2_no_code", 32'(ccount), 32'd0);

        // 3: moles 2 and 5 on the same edge
        clr_counts();
        btn_n = 5'b01101; ticks(15);
        btn_n = 5'b11111; ticks(10);
        chk("s3_valid_pulses", 32'(vcount), MULTI_EN ? 32'd0 : 32'd1);
        chk("s3_code_cycles", 32'(ccount), MULTI_EN ? 32'd0 : 32'd3);
        chk("s3_multi_pulses", 32'(mcount), MULTI_EN ? 32'd1 : 32'd0);

        // 4: second press during HOLD is ignored, fresh press later is accepted
        clr_counts();
        btn_n = 5'b10111; ticks(7);
        btn_n = 5'b10110; ticks(10);
        btn_n = 5'b11111; ticks(10);
        btn_n = 5'b11110; ticks(12);
        btn_n = 5'b11111; ticks(10);
        chk("s4_valid_pulses", 32'(vcount), 32'd2);

        // 5: press while disabled, enable while held, then re-press
        clr_counts();
        enable = 1'b0; btn_n = 5'b11011; ticks(10);
        enable = 1'b1; ticks(10);
        chk("s5_no_hit_held", 32'(vcount), 32'd0);
        btn_n = 5'b11111; ticks(10);
        btn_n = 5'b11011; ticks(12);
        btn_n = 5'b11111; ticks(10);
        chk("s5_valid_pulses", 32'(vcount), 32'd1);

        // 6: asynchronous reset in the middle of a mole-5 hold
        btn_n = 5'b01111;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (hit_code === 3'b101) got = 1'b1;
        end
        chk("s6_reach_m5", 32'(got), 32'd1);
        tick();
        #2; reset = 1'b0; #1;
        model_reset();
        chk("s6_async_code", 32'(hit_code), 32'h0);
        chk("s6_async_busy", 32'(busy), 32'h0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
        clr_counts();
        ticks(D + 1);
        chk("s6_debounce_wait", 32'(ccount), 32'd0);
        ticks(15);
        btn_n = 5'b11111; ticks(10);

        // Random button traffic with occasional enable toggles.
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, 9);
                if (r < 4) btn_n = 5'b11111;
                else if (r < 8) btn_n = ~(5'b00001 << $urandom_range(0, 4));
                else if (r == 8) btn_n = 5'($urandom);
            end
            if ($urandom_range(0, 40) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 4) == 0) enable = 1'b1;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
